mem_port_arbiter: RTL and testbench

- Shares the single PDP-8 memory port between two requesters: the instruction fetch/decode unit (instruction reads) and the execution unit (operand reads and writes).
- Sequences each access through a small FSM, waits a fixed memory read latency, and routes returned data to the correct requester.
- Execution unit has priority; a starvation guard guarantees instruction fetch progress.
- Sits between the IFD/exec units and the memory model.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch
// reads and execution-unit reads/writes, with a fetch starvation guard.
module mem_port_arbiter #(
   parameter int DATA_WIDTH   = 12,
   parameter int ADDR_WIDTH   = 12,
   parameter int RD_LATENCY   = 2,
   parameter int MAX_EXEC_RUN = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ifu_rd_req,
   input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic [DATA_WIDTH-1:0] ifu_rd_data,
   output logic                  ifu_rd_valid,
   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  exec_rd_valid,
   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic                  exec_wr_done,
   output logic                  mem_rd_req,
   output logic                  mem_wr_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   localparam int RUN_W = $clog2(MAX_EXEC_RUN + 1);
   localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_EXEC_RUN);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      COMPLETE
   } state_t;

   typedef enum logic [1:0] {
      OWN_IFU,
      OWN_ERD,
      OWN_EWR
   } owner_t;

   state_t                state, state_nx;
   owner_t                owner, owner_nx;
   logic [2:0]            lat_cnt, lat_nx;
   logic [RUN_W-1:0]      run_cnt, run_nx;
   logic                  grant;
   logic                  capture;
   logic [ADDR_WIDTH-1:0] gaddr;

   // Arbitration, access sequencing and response strobes
   always_comb begin
      state_nx      = state;
      owner_nx      = owner;
      lat_nx        = lat_cnt;
      run_nx        = run_cnt;
      grant         = 1'b0;
      capture       = 1'b0;
      gaddr         = ifu_rd_addr;
      mem_rd_req    = 1'b0;
      mem_wr_req    = 1'b0;
      ifu_rd_valid  = 1'b0;
      exec_rd_valid = 1'b0;
      exec_wr_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!ifu_rd_req)
               run_nx = '0;
            if (ifu_rd_req && run_cnt == RUN_MAX) begin
               grant    = 1'b1;
               owner_nx = OWN_IFU;
               gaddr    = ifu_rd_addr;
            end else if (exec_wr_req) begin
               grant    = 1'b1;
               owner_nx = OWN_EWR;
               gaddr    = exec_wr_addr;
            end else if (exec_rd_req) begin
               grant    = 1'b1;
               owner_nx = OWN_ERD;
               gaddr    = exec_rd_addr;
            end else if (ifu_rd_req) begin
               grant    = 1'b1;
               owner_nx = OWN_IFU;
               gaddr    = ifu_rd_addr;
            end
            if (grant) begin
               state_nx = ISSUE;
               if (owner_nx == OWN_IFU)
                  run_nx = '0;
               else if (ifu_rd_req && run_cnt != RUN_MAX)
                  run_nx = run_cnt + 1'b1;
            end
         end
         ISSUE: begin
            if (owner == OWN_EWR) begin
               mem_wr_req = 1'b1;
               state_nx   = COMPLETE;
            end else begin
               mem_rd_req = 1'b1;
               lat_nx     = LAT_INIT;
               state_nx   = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == 3'd0) begin
               capture  = 1'b1;
               state_nx = COMPLETE;
            end else begin
               lat_nx = lat_cnt - 3'd1;
            end
         end
         COMPLETE: begin
            ifu_rd_valid  = (owner == OWN_IFU);
            exec_rd_valid = (owner == OWN_ERD);
            exec_wr_done  = (owner == OWN_EWR);
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state, owner, latency and exec-run counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         owner   <= OWN_IFU;
         lat_cnt <= '0;
         run_cnt <= '0;
      end else begin
         state   <= state_nx;
         owner   <= owner_nx;
         lat_cnt <= lat_nx;
         run_cnt <= run_nx;
      end
   end

   // Memory address and write data latched at grant, held afterwards
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_addr    <= '0;
         mem_wr_data <= '0;
      end else if (grant) begin
         mem_addr <= gaddr;
         if (owner_nx == OWN_EWR)
            mem_wr_data <= exec_wr_data;
      end
   end

   // Read data routed to the owning requester's holding register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ifu_rd_data  <= '0;
         exec_rd_data <= '0;
      end else if (capture) begin
         if (owner == OWN_IFU)
            ifu_rd_data <= mem_rd_data;
         else
            exec_rd_data <= mem_rd_data;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (read latency 2 and 1) driven by
// directed and random requesters, checked against a transaction model.
module tb_mem_port_arbiter;

   localparam int MAXR = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        ifu_req[2];
   logic [11:0] ifu_addr[2];
   logic [11:0] ifu_data[2];
   logic        ifu_valid[2];
   logic        erd_req[2];
   logic [11:0] erd_addr[2];
   logic [11:0] erd_data[2];
   logic        erd_valid[2];
   logic        ewr_req[2];
   logic [11:0] ewr_addr[2];
   logic [11:0] ewr_wdata[2];
   logic        ewr_done[2];
   logic        mrd[2];
   logic        mwr[2];
   logic [11:0] maddr[2];
   logic [11:0] mwdata[2];
   logic [11:0] mrdata[2];

   logic [11:0] mem[2][4096];
   logic [11:0] ref_mem[2][4096];
   int          rd_due[2];
   logic [11:0] rd_adr[2];
   logic        s_rd[2];
   logic        s_wr[2];
   logic [11:0] s_addr[2];
   logic [11:0] s_wdata[2];

   bit          busy[2];
   int          t_grant[2];
   int          t_resp[2];
   int          own[2];
   int          streak[2];
   int          fin[2];
   logic [11:0] m_addr[2];
   logic [11:0] m_wdata[2];
   logic [11:0] m_rdata[2];
   bit          e_rd[2];
   bit          e_wr[2];
   bit          e_iv[2];
   bit          e_rv[2];
   bit          e_wd[2];
   logic [11:0] e_idata[2];
   logic [11:0] e_rdata[2];

   byte         ev[2][256];
   logic [11:0] evd[2][256];
   int          ev_n[2];

   bit          auto_on;
   bit          hold_exec;
   logic        rst_want;
   int          cyc;
   int          tests;
   int          fails;

   always #5 clk = ~clk;

   mem_port_arbiter #(.RD_LATENCY(2)) u_l2 (
      .clk(clk), .reset_n(rst_n),
      .ifu_rd_req(ifu_req[0]), .ifu_rd_addr(ifu_addr[0]),
      .ifu_rd_data(ifu_data[0]), .ifu_rd_valid(ifu_valid[0]),
      .exec_rd_req(erd_req[0]), .exec_rd_addr(erd_addr[0]),
      .exec_rd_data(erd_data[0]), .exec_rd_valid(erd_valid[0]),
      .exec_wr_req(ewr_req[0]), .exec_wr_addr(ewr_addr[0]),
      .exec_wr_data(ewr_wdata[0]), .exec_wr_done(ewr_done[0]),
      .mem_rd_req(mrd[0]), .mem_wr_req(mwr[0]),
      .mem_addr(maddr[0]), .mem_wr_data(mwdata[0]),
      .mem_rd_data(mrdata[0])
   );

   mem_port_arbiter #(.RD_LATENCY(1)) u_l1 (
      .clk(clk), .reset_n(rst_n),
      .ifu_rd_req(ifu_req[1]), .ifu_rd_addr(ifu_addr[1]),
      .ifu_rd_data(ifu_data[1]), .ifu_rd_valid(ifu_valid[1]),
      .exec_rd_req(erd_req[1]), .exec_rd_addr(erd_addr[1]),
      .exec_rd_data(erd_data[1]), .exec_rd_valid(erd_valid[1]),
      .exec_wr_req(ewr_req[1]), .exec_wr_addr(ewr_addr[1]),
      .exec_wr_data(ewr_wdata[1]), .exec_wr_done(ewr_done[1]),
      .mem_rd_req(mrd[1]), .mem_wr_req(mwr[1]),
      .mem_addr(maddr[1]), .mem_wr_data(mwdata[1]),
      .mem_rd_data(mrdata[1])
   );

   function automatic int lat(int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic logic [11:0] rnd_addr();
      return 12'($urandom_range(0, 63));
   endfunction

   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (lat %0d, cycle %0d): got %0h, expected %0h",
                  nm, lat(k), cyc, act, exp);
      end
   endtask

   // End of cycle: retire the finished access, arbitrate when idle
   task automatic model_cycle(int k);
      bit idle;
      int w;
      fin[k] = 0;
      if (!rst_n)
         return;
      idle = !busy[k];
      if (busy[k] && cyc == t_resp[k]) begin
         busy[k] = 1'b0;
         fin[k]  = own[k];
      end
      if (!idle)
         return;
      w = 0;
      if (!ifu_req[k])
         streak[k] = 0;
      if (ifu_req[k] && streak[k] == MAXR) w = 1;
      else if (ewr_req[k])                 w = 3;
      else if (erd_req[k])                 w = 2;
      else if (ifu_req[k])                 w = 1;
      if (w == 0)
         return;
      busy[k]    = 1'b1;
      own[k]     = w;
      t_grant[k] = cyc;
      if (w == 1) m_addr[k] = ifu_addr[k];
      if (w == 2) m_addr[k] = erd_addr[k];
      if (w == 3) begin
         m_addr[k]  = ewr_addr[k];
         m_wdata[k] = ewr_wdata[k];
         ref_mem[k][m_addr[k]] = m_wdata[k];
         t_resp[k] = cyc + 2;
      end else begin
         m_rdata[k] = ref_mem[k][m_addr[k]];
         t_resp[k]  = cyc + 2 + lat(k);
      end
      if (w == 1)
         streak[k] = 0;
      else if (ifu_req[k] && streak[k] < MAXR)
         streak[k]++;
   endtask

   // Requesters: drop (or renew) after a response, raise new ones randomly
   task automatic drive_reqs(int k);
      if (fin[k] == 1) begin
         if (auto_on && $urandom_range(0, 1) == 1) ifu_addr[k] = rnd_addr();
         else ifu_req[k] = 1'b0;
      end
      if (fin[k] == 2) begin
         if (hold_exec || (auto_on && $urandom_range(0, 1) == 1))
            erd_addr[k] = rnd_addr();
         else
            erd_req[k] = 1'b0;
      end
      if (fin[k] == 3) begin
         if (auto_on && $urandom_range(0, 1) == 1) begin
            ewr_addr[k]  = rnd_addr();
            ewr_wdata[k] = 12'($urandom);
         end else begin
            ewr_req[k] = 1'b0;
         end
      end
      if (auto_on) begin
         if (!ifu_req[k] && $urandom_range(0, 3) == 0) begin
            ifu_req[k]  = 1'b1;
            ifu_addr[k] = rnd_addr();
         end
         if (!erd_req[k] && $urandom_range(0, 3) == 0) begin
            erd_req[k]  = 1'b1;
            erd_addr[k] = rnd_addr();
         end
         if (!ewr_req[k] && $urandom_range(0, 5) == 0) begin
            ewr_req[k]   = 1'b1;
            ewr_addr[k]  = rnd_addr();
            ewr_wdata[k] = 12'($urandom);
         end
      end
   endtask

   // One clock: memory, model and stimulus after the edge; compare at negedge
   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (s_wr[k]) mem[k][s_addr[k]] = s_wdata[k];
         if (s_rd[k]) begin
            rd_due[k] = cyc + lat(k);
            rd_adr[k] = s_addr[k];
         end
         model_cycle(k);
         drive_reqs(k);
      end
      rst_n = rst_want;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            busy[k]    = 1'b0;
            streak[k]  = 0;
            e_idata[k] = '0;
            e_rdata[k] = '0;
            rd_due[k]  = -1;
         end
         e_rd[k] = busy[k] && cyc == t_grant[k] + 1 && own[k] != 3;
         e_wr[k] = busy[k] && cyc == t_grant[k] + 1 && own[k] == 3;
         e_iv[k] = busy[k] && cyc == t_resp[k] && own[k] == 1;
         e_rv[k] = busy[k] && cyc == t_resp[k] && own[k] == 2;
         e_wd[k] = busy[k] && cyc == t_resp[k] && own[k] == 3;
         if (e_iv[k]) e_idata[k] = m_rdata[k];
         if (e_rv[k]) e_rdata[k] = m_rdata[k];
         mrdata[k] = (cyc == rd_due[k]) ? mem[k][rd_adr[k]] : 12'($urandom);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         s_rd[k]    = mrd[k];
         s_wr[k]    = mwr[k];
         s_addr[k]  = maddr[k];
         s_wdata[k] = mwdata[k];
         chk("mem_rd_req", k, 32'(mrd[k]), 32'(e_rd[k]));
         chk("mem_wr_req", k, 32'(mwr[k]), 32'(e_wr[k]));
         chk("one_strobe", k, 32'(mrd[k] & mwr[k]), 32'(0));
         if (e_rd[k] || e_wr[k])
            chk("mem_addr", k, 32'(maddr[k]), 32'(m_addr[k]));
         if (e_wr[k])
            chk("mem_wr_data", k, 32'(mwdata[k]), 32'(m_wdata[k]));
         chk("ifu_rd_valid", k, 32'(ifu_valid[k]), 32'(e_iv[k]));
         chk("exec_rd_valid", k, 32'(erd_valid[k]), 32'(e_rv[k]));
         chk("exec_wr_done", k, 32'(ewr_done[k]), 32'(e_wd[k]));
         chk("ifu_rd_data", k, 32'(ifu_data[k]), 32'(e_idata[k]));
         chk("exec_rd_data", k, 32'(erd_data[k]), 32'(e_rdata[k]));
         if (ev_n[k] < 250) begin
            if (ifu_valid[k]) begin
               ev[k][ev_n[k]] = "I"; evd[k][ev_n[k]] = ifu_data[k]; ev_n[k]++;
            end
            if (erd_valid[k]) begin
               ev[k][ev_n[k]] = "R"; evd[k][ev_n[k]] = erd_data[k]; ev_n[k]++;
            end
            if (ewr_done[k]) begin
               ev[k][ev_n[k]] = "W"; evd[k][ev_n[k]] = '0; ev_n[k]++;
            end
         end
      end
   endtask

   task automatic quiesce(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic outputs_zero(string nm);
      for (int k = 0; k < 2; k++) begin
         chk({nm, "_ctrl"}, k,
             32'({ifu_valid[k], erd_valid[k], ewr_done[k], mrd[k], mwr[k]}), 32'(0));
         chk({nm, "_mem_addr"}, k, 32'(maddr[k]), 32'(0));
         chk({nm, "_mem_wr_data"}, k, 32'(mwdata[k]), 32'(0));
         chk({nm, "_ifu_data"}, k, 32'(ifu_data[k]), 32'(0));
         chk({nm, "_exec_data"}, k, 32'(erd_data[k]), 32'(0));
      end
   endtask

   // Single fetch from idle: strobe one cycle after grant, valid 2+L after
   task automatic fetch(logic [11:0] a, logic [11:0] d, string nm);
      for (int k = 0; k < 2; k++) begin
         mem[k][a]     = d;
         ref_mem[k][a] = d;
         ifu_req[k]    = 1'b1;
         ifu_addr[k]   = a;
      end
      for (int dd = 1; dd <= 4; dd++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            chk({nm, "_strobe"}, k, 32'(mrd[k]), 32'(dd == 1));
            chk({nm, "_valid"}, k, 32'(ifu_valid[k]), 32'(dd == 2 + lat(k)));
            if (dd == 2 + lat(k))
               chk({nm, "_data"}, k, 32'(ifu_data[k]), 32'(d));
         end
      end
      quiesce(4);
   endtask

   initial begin
      int    b[2];
      string order;
      tests = 0;
      fails = 0;
      cyc = 0;
      auto_on = 1'b0;
      hold_exec = 1'b0;
      rst_want = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ifu_req[k] = 1'b0; ifu_addr[k] = '0;
         erd_req[k] = 1'b0; erd_addr[k] = '0;
         ewr_req[k] = 1'b0; ewr_addr[k] = '0; ewr_wdata[k] = '0;
         mrdata[k] = '0; rd_due[k] = -1; rd_adr[k] = '0;
         s_rd[k] = 1'b0; s_wr[k] = 1'b0; s_addr[k] = '0; s_wdata[k] = '0;
         busy[k] = 1'b0; t_grant[k] = -10; t_resp[k] = -10; own[k] = 0;
         streak[k] = 0; fin[k] = 0;
         m_addr[k] = '0; m_wdata[k] = '0; m_rdata[k] = '0;
         e_idata[k] = '0; e_rdata[k] = '0;
         ev_n[k] = 0;
         for (int i = 0; i < 256; i++) begin
            ev[k][i] = 0; evd[k][i] = '0;
         end
         for (int i = 0; i < 4096; i++) begin
            mem[k][i]     = 12'(i * 5 + 3);
            ref_mem[k][i] = 12'(i * 5 + 3);
         end
      end

      quiesce(3);
      outputs_zero("reset");
      rst_want = 1'b1;
      quiesce(3);

      fetch(12'o200, 12'o7001, "fetch");

      for (int k = 0; k < 2; k++) begin
         b[k] = ev_n[k];
         ewr_req[k] = 1'b1; ewr_addr[k] = 12'o300; ewr_wdata[k] = 12'o1234;
         erd_req[k] = 1'b1; erd_addr[k] = 12'o300;
      end
      quiesce(20);
      for (int k = 0; k < 2; k++) begin
         chk("wr_first", k, 32'(ev[k][b[k]]), 32'("W"));
         chk("rd_second", k, 32'(ev[k][b[k] + 1]), 32'("R"));
         chk("rd_after_wr_data", k, 32'(evd[k][b[k] + 1]), 32'(12'o1234));
      end

      for (int k = 0; k < 2; k++) begin
         b[k] = ev_n[k];
         mem[k][12'o201] = 12'o4321; ref_mem[k][12'o201] = 12'o4321;
         ifu_req[k] = 1'b1; ifu_addr[k] = 12'o201;
         erd_req[k] = 1'b1; erd_addr[k] = 12'o202;
      end
      quiesce(20);
      for (int k = 0; k < 2; k++) begin
         chk("contend_exec_first", k, 32'(ev[k][b[k]]), 32'("R"));
         chk("contend_ifu_next", k, 32'(ev[k][b[k] + 1]), 32'("I"));
         chk("contend_ifu_data", k, 32'(evd[k][b[k] + 1]), 32'(12'o4321));
      end

      hold_exec = 1'b1;
      for (int k = 0; k < 2; k++) begin
         b[k] = ev_n[k];
         ifu_req[k] = 1'b1; ifu_addr[k] = 12'o205;
         erd_req[k] = 1'b1; erd_addr[k] = rnd_addr();
      end
      for (int i = 0; i < 200; i++) begin
         if (ev_n[0] >= b[0] + 6 && ev_n[1] >= b[1] + 6) break;
         step();
      end
      hold_exec = 1'b0;
      quiesce(20);
      order = "RRRRIR";
      for (int k = 0; k < 2; k++) begin
         chk("starve_count", k, 32'(ev_n[k] - b[k] >= 6), 32'(1));
         for (int i = 0; i < 6; i++)
            chk("starve_order", k, 32'(ev[k][b[k] + i]), 32'(order[i]));
      end

      for (int k = 0; k < 2; k++) begin
         ifu_req[k] = 1'b1; ifu_addr[k] = 12'o210;
      end
      step();
      for (int k = 0; k < 2; k++)
         chk("pre_reset_strobe", k, 32'(mrd[k]), 32'(1));
      rst_want = 1'b0;
      step();
      outputs_zero("mid_reset");
      for (int k = 0; k < 2; k++) begin
         ifu_req[k] = 1'b0;
         b[k] = ev_n[k];
      end
      rst_want = 1'b1;
      quiesce(10);
      for (int k = 0; k < 2; k++)
         chk("no_valid_after_reset", k, 32'(ev_n[k] - b[k]), 32'(0));
      fetch(12'o210, 12'o5555, "post_reset_fetch");
      fetch(12'o400, 12'o7402, "lat_sweep_fetch");

      auto_on = 1'b1;
      quiesce(3000);
      auto_on = 1'b0;
      quiesce(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
